// File: rtl/axi_ram_slave.sv
// AXI3 responder over a 2^MEM_AW x 32b RAM; read and write burst engines run independently.
// Reads take 2 cycles/beat with R held until rready; writes take 1 beat/cycle with B held until bready.
module axi_ram_slave #(
   parameter int MEM_AW = 12,
   parameter int ID_W   = 4
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [3:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic [1:0]      arlock,
   input  logic [3:0]      arcache,
   input  logic [2:0]      arprot,
   input  logic            arvalid,
   output logic            arready,
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [3:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic [1:0]      awlock,
   input  logic [3:0]      awcache,
   input  logic [2:0]      awprot,
   input  logic            awvalid,
   output logic            awready,
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);
   typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, mask, nxt;
      step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
      mask = ({28'd0, len} + 32'd1) * step - 32'd1;
      nxt  = addr + step;
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | (nxt & mask);
         default: next_addr = nxt;
      endcase
   endfunction

   r_state_t        r_state_q, r_state_d;
   logic [ID_W-1:0] r_id_q, r_id_d;
   logic [31:0]     r_addr_q, r_addr_d;
   logic [3:0]      r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]      r_size_q, r_size_d;
   logic [1:0]      r_burst_q, r_burst_d;
   w_state_t        w_state_q, w_state_d;
   logic [ID_W-1:0] w_id_q, w_id_d;
   logic [31:0]     w_addr_q, w_addr_d;
   logic [3:0]      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]      w_size_q, w_size_d;
   logic [1:0]      w_burst_q, w_burst_d;
   logic            w_err_q, w_err_d;
   logic            init_q, init_d;
   logic [31:0]     rdata_q;
   logic [31:0]     mem [2**MEM_AW];
   logic            r_last, w_last, mem_we;
   logic            unused_ok;

   assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   // Keeps both address channels closed until the first edge after reset release.
   assign init_d  = 1'b1;
   assign r_last  = (r_cnt_q == r_len_q);
   assign w_last  = (w_cnt_q == w_len_q);
   assign arready = init_q && (r_state_q == R_IDLE);
   assign awready = init_q && (w_state_q == W_IDLE);
   assign rvalid  = (r_state_q == R_DATA);
   assign rdata   = rvalid ? rdata_q : 32'd0;
   assign rid     = rvalid ? r_id_q : '0;
   assign rlast   = rvalid && r_last;
   assign rresp   = 2'b00;
   assign wready  = (w_state_q == W_DATA);
   assign mem_we  = wready && wvalid;
   assign bvalid  = (w_state_q == W_RESP);
   assign bid     = bvalid ? w_id_q : '0;
   assign bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_cnt_d   = r_cnt_q;
      case (r_state_q)
         R_IDLE: if (arvalid && arready) begin
            r_id_d    = arid;
            r_addr_d  = araddr;
            r_len_d   = arlen;
            r_size_d  = arsize;
            r_burst_d = arburst;
            r_cnt_d   = 4'd0;
            r_state_d = R_READ;
         end
         R_READ: r_state_d = R_DATA;
         R_DATA: if (rready) begin
            if (r_last) begin
               r_state_d = R_IDLE;
            end else begin
               r_addr_d  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
               r_cnt_d   = r_cnt_q + 4'd1;
               r_state_d = R_READ;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      case (w_state_q)
         W_IDLE: if (awvalid && awready) begin
            w_id_d    = awid;
            w_addr_d  = awaddr;
            w_len_d   = awlen;
            w_size_d  = awsize;
            w_burst_d = awburst;
            w_cnt_d   = 4'd0;
            w_err_d   = 1'b0;
            w_state_d = W_DATA;
         end
         // The beat count, not wlast, terminates the burst; a disagreeing wlast only flags SLVERR.
         W_DATA: if (wvalid) begin
            w_err_d = w_err_q | (wlast != w_last);
            if (w_last) begin
               w_state_d = W_RESP;
            end else begin
               w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
               w_cnt_d  = w_cnt_q + 4'd1;
            end
         end
         W_RESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         init_q    <= 1'b0;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= 32'd0;
         r_len_q   <= 4'd0;
         r_size_q  <= 3'd0;
         r_burst_q <= 2'd0;
         r_cnt_q   <= 4'd0;
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= 32'd0;
         w_len_q   <= 4'd0;
         w_size_q  <= 3'd0;
         w_burst_q <= 2'd0;
         w_cnt_q   <= 4'd0;
         w_err_q   <= 1'b0;
      end else begin
         init_q    <= init_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_cnt_q   <= r_cnt_d;
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
      end
   end

   // RAM is never reset; non-blocking update gives read-first on a same-word collision.
   always_ff @(posedge aclk) begin
      if (r_state_q == R_READ) rdata_q <= mem[r_addr_q[MEM_AW+1:2]];
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end
endmodule
